// File: rtl/actel_s_bank_if.sv
// Bus bundle for actel_s_bank: control, select gating, data sources, scan and outputs.
interface actel_s_bank_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sclr;
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] d00;
    logic [WIDTH-1:0] d01;
    logic [WIDTH-1:0] d10;
    logic [WIDTH-1:0] d11;
    logic             a1;
    logic             b1;
    logic             a0;
    logic             b0;
    logic             scan_en;
    logic             scan_in;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             scan_out;

    modport master (
        output sclr, en, in_valid, d00, d01, d10, d11, a1, b1, a0, b0, scan_en, scan_in,
        input  out, out_valid, scan_out
    );

    modport slave (
        input  sclr, en, in_valid, d00, d01, d10, d11, a1, b1, a0, b0, scan_en, scan_in,
        output out, out_valid, scan_out
    );
endinterface

// File: rtl/actel_s_bank.sv
// Pipelined bank of Actel S-module style registered 4:1 muxes with a shared gated select,
// clock enable, synchronous clear, valid tracking and a scan path through the capture stage.
module actel_s_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STAGES   = 1,
    parameter int unsigned SEL_MODE = 0
) (
    input  logic           clk,
    input  logic           clr,
    actel_s_bank_if.slave  bus
);

    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] mux;
    logic [WIDTH-1:0] stage [STAGES];
    logic [STAGES-1:0] vld;

    always_comb begin
        s1 = bus.a1 | bus.b1;
        s0 = bus.a0 & bus.b0;
        if (SEL_MODE == 1) begin
            s1 = bus.a1 & bus.b1;
        end else if (SEL_MODE == 2) begin
            s0 = bus.a0 | bus.b0;
        end
    end

    always_comb begin
        mux = bus.d00;
        unique case ({s1, s0})
            2'b00: mux = bus.d00;
            2'b01: mux = bus.d01;
            2'b10: mux = bus.d10;
            2'b11: mux = bus.d11;
        endcase
    end

    // Shift is written as a shift-and-or so WIDTH=1 needs no special case.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage[k] <= '0;
            end
            vld <= '0;
        end else if (bus.sclr) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage[k] <= '0;
            end
            vld <= '0;
        end else if (bus.scan_en) begin
            stage[0] <= (stage[0] << 1) | WIDTH'(bus.scan_in);
            vld[0]   <= 1'b0;
        end else if (bus.en) begin
            stage[0] <= mux;
            vld[0]   <= bus.in_valid;
            for (int k = 1; k < int'(STAGES); k++) begin
                stage[k] <= stage[k-1];
                vld[k]   <= vld[k-1];
            end
        end
    end

    assign bus.out       = stage[STAGES-1];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.scan_out  = stage[0][WIDTH-1];

endmodule

// File: tb/tb_actel_s_bank.sv
// Directed bench for actel_s_bank: select sweep over all gating modes, pipeline stall,
// scan load, clear priority and asynchronous clear, across several parameter sets.
module tb_actel_s_bank;

    logic       clk = 1'b0;
    logic       clr;
    logic       sclr, en, in_valid, scan_en, scan_in;
    logic [3:0] gate;  // {a1, b1, a0, b0}
    logic [7:0] d00, d01, d10, d11;
    logic [3:0] sbits;
    logic [3:0] sexp;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    actel_s_bank_if #(.WIDTH(8)) bus0 ();
    actel_s_bank_if #(.WIDTH(8)) bus1 ();
    actel_s_bank_if #(.WIDTH(8)) bus2 ();
    actel_s_bank_if #(.WIDTH(8)) bus3 ();
    actel_s_bank_if #(.WIDTH(4)) bus4 ();

    assign {bus0.sclr, bus0.en, bus0.in_valid, bus0.a1, bus0.b1, bus0.a0, bus0.b0,
            bus0.scan_en, bus0.scan_in} = {sclr, en, in_valid, gate, scan_en, scan_in};
    assign {bus0.d00, bus0.d01, bus0.d10, bus0.d11} = {d00, d01, d10, d11};
    assign {bus1.sclr, bus1.en, bus1.in_valid, bus1.a1, bus1.b1, bus1.a0, bus1.b0,
            bus1.scan_en, bus1.scan_in} = {sclr, en, in_valid, gate, scan_en, scan_in};
    assign {bus1.d00, bus1.d01, bus1.d10, bus1.d11} = {d00, d01, d10, d11};
    assign {bus2.sclr, bus2.en, bus2.in_valid, bus2.a1, bus2.b1, bus2.a0, bus2.b0,
            bus2.scan_en, bus2.scan_in} = {sclr, en, in_valid, gate, scan_en, scan_in};
    assign {bus2.d00, bus2.d01, bus2.d10, bus2.d11} = {d00, d01, d10, d11};
    assign {bus3.sclr, bus3.en, bus3.in_valid, bus3.a1, bus3.b1, bus3.a0, bus3.b0,
            bus3.scan_en, bus3.scan_in} = {sclr, en, in_valid, gate, scan_en, scan_in};
    assign {bus3.d00, bus3.d01, bus3.d10, bus3.d11} = {d00, d01, d10, d11};
    assign {bus4.sclr, bus4.en, bus4.in_valid, bus4.a1, bus4.b1, bus4.a0, bus4.b0,
            bus4.scan_en, bus4.scan_in} = {sclr, en, in_valid, gate, scan_en, scan_in};
    assign {bus4.d00, bus4.d01, bus4.d10, bus4.d11} = {d00[3:0], d01[3:0], d10[3:0], d11[3:0]};

    actel_s_bank #(.WIDTH(8), .STAGES(1), .SEL_MODE(0)) u0 (.clk(clk), .clr(clr), .bus(bus0));
    actel_s_bank #(.WIDTH(8), .STAGES(1), .SEL_MODE(1)) u1 (.clk(clk), .clr(clr), .bus(bus1));
    actel_s_bank #(.WIDTH(8), .STAGES(1), .SEL_MODE(2)) u2 (.clk(clk), .clr(clr), .bus(bus2));
    actel_s_bank #(.WIDTH(8), .STAGES(3), .SEL_MODE(0)) u3 (.clk(clk), .clr(clr), .bus(bus3));
    actel_s_bank #(.WIDTH(4), .STAGES(2), .SEL_MODE(0)) u4 (.clk(clk), .clr(clr), .bus(bus4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        {sclr, en, in_valid, scan_en, scan_in} = '0;
        gate = 4'b0000;
        {d00, d01, d10, d11} = '0;
        #13;
        check("reset_out", bus0.out, 8'h00);
        check("reset_valid", bus0.out_valid, 1'b0);
        check("reset_out_s3", bus3.out, 8'h00);
        check("reset_scan_out", bus4.scan_out, 1'b0);
        clr = 1'b0;

        // Select sweep, SEL_MODE 0
        d00 = 8'h11; d01 = 8'h22; d10 = 8'h44; d11 = 8'h88;
        en = 1'b1; in_valid = 1'b1;
        gate = 4'b0000; step(1);
        check("sel_0000", bus0.out, 8'h11);
        check("sel_valid", bus0.out_valid, 1'b1);
        gate = 4'b0011; step(1);
        check("sel_0011", bus0.out, 8'h22);
        gate = 4'b1000; step(1);
        check("sel_1000", bus0.out, 8'h44);
        gate = 4'b0111; step(1);
        check("sel_0111", bus0.out, 8'h88);

        // a1=1 b1=0 a0=1 b0=0 across the three gating modes
        gate = 4'b1010; step(1);
        check("mode0_1010", bus0.out, 8'h44);
        check("mode1_1010", bus1.out, 8'h11);
        check("mode2_1010", bus2.out, 8'h88);

        // Pipeline with stall, STAGES=3
        pulse_clr();
        gate = 4'b0000; d00 = 8'hA5; in_valid = 1'b1; en = 1'b1;
        step(1);
        en = 1'b0; in_valid = 1'b0; d00 = 8'h00;
        step(1);
        check("stall1_out", bus3.out, 8'h00);
        check("stall1_valid", bus3.out_valid, 1'b0);
        step(1);
        check("stall2_out", bus3.out, 8'h00);
        check("stall2_valid", bus3.out_valid, 1'b0);
        en = 1'b1;
        step(1);
        check("pipe_en1_valid", bus3.out_valid, 1'b0);
        step(1);
        check("pipe_en2_out", bus3.out, 8'hA5);
        check("pipe_en2_valid", bus3.out_valid, 1'b1);

        // sclr beats scan_en and en
        d00 = 8'hFF; in_valid = 1'b1;
        step(1);
        sclr = 1'b1; scan_en = 1'b1; scan_in = 1'b1;
        step(1);
        check("prio_out_s3", bus3.out, 8'h00);
        check("prio_valid_s3", bus3.out_valid, 1'b0);
        check("prio_out_s1", bus0.out, 8'h00);
        check("prio_scan_out", bus4.scan_out, 1'b0);
        sclr = 1'b0; scan_en = 1'b0; scan_in = 1'b0;

        // Scan load on WIDTH=4, STAGES=2 with a valid word parked in the last stage
        pulse_clr();
        en = 1'b1; in_valid = 1'b1; d00 = 8'h06;
        step(1);
        in_valid = 1'b0; d00 = 8'h00;
        step(1);
        check("prescan_out", bus4.out, 4'h6);
        check("prescan_valid", bus4.out_valid, 1'b1);
        sbits = 4'b1101;  // shifted in order 1,0,1,1
        sexp  = 4'b1000;  // scan_out after each shift: 0,0,0,1
        scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            scan_in = sbits[i];
            step(1);
            check($sformatf("scan_out_%0d", i), bus4.scan_out, sexp[i]);
            check($sformatf("scan_hold_out_%0d", i), bus4.out, 4'h6);
            check($sformatf("scan_hold_valid_%0d", i), bus4.out_valid, 1'b1);
        end
        scan_en = 1'b0; scan_in = 1'b0;
        step(1);
        check("scan_word", bus4.out, 4'b1011);
        check("scan_vld0", bus4.out_valid, 1'b0);

        // Asynchronous clear between edges, STAGES=2
        in_valid = 1'b1; d00 = 8'h03;
        step(2);
        check("preclr_out", bus4.out, 4'h3);
        check("preclr_valid", bus4.out_valid, 1'b1);
        #3;
        clr = 1'b1;
        #1;
        check("aclr_out", bus4.out, 4'h0);
        check("aclr_valid", bus4.out_valid, 1'b0);
        check("aclr_out_s3", bus3.out, 8'h00);
        clr = 1'b0;
        step(1);
        check("postclr_out", bus4.out, 4'h0);
        step(1);
        check("postclr_out2", bus4.out, 4'h3);
        check("postclr_valid2", bus4.out_valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
